// File: rtl/dp_ram_pkg.sv
// Shared definitions for the LPC/MCU buffer-RAM bridge: FSM encoding and
// byte-lane helpers used by the lane mux.
package dp_ram_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_WAIT   = 2'd2,
        ST_ACK    = 2'd3
    } state_t;

    // Logical byte lane (from the byte address) to physical lane in the RAM word.
    function automatic int unsigned phys_lane(input int unsigned lane,
                                              input int unsigned lanes,
                                              input logic        big_endian);
        return big_endian ? (lanes - 1 - lane) : lane;
    endfunction

    // One bit of a one-hot byte-enable vector: set only on the addressed lane.
    function automatic logic be_hit(input int unsigned phys,
                                    input int unsigned lane);
        return phys == lane;
    endfunction

endpackage

// File: rtl/dp_lane_mux.sv
// Byte-port lane steering: one-hot write enable, byte replication for writes
// and byte extraction for reads, all in the configured endianness.
module dp_lane_mux
    import dp_ram_pkg::*;
#(
    parameter  int DATA_W     = 32,
    parameter  int BIG_ENDIAN = 0,
    localparam int LANES      = DATA_W / 8,
    localparam int LB         = $clog2(LANES)
) (
    input  logic [LB-1:0]     i_lane,
    input  logic [7:0]        i_wbyte,
    input  logic [DATA_W-1:0] i_word,
    output logic [LANES-1:0]  o_be,
    output logic [DATA_W-1:0] o_wdata,
    output logic [7:0]        o_rbyte
);

    logic [LB-1:0] w_phys;

    assign w_phys  = LB'(phys_lane(32'(i_lane), LANES, BIG_ENDIAN != 0));
    // The byte lands on every lane; only the enabled lane is actually written.
    assign o_wdata = {LANES{i_wbyte}};

    // Decode the physical lane into byte enables and pick the read byte.
    always_comb begin
        o_be    = '0;
        o_rbyte = '0;
        for (int p = 0; p < LANES; p++) begin
            o_be[p] = be_hit(32'(w_phys), p);
            if (be_hit(32'(w_phys), p)) begin
                o_rbyte = i_word[8*p +: 8];
            end
        end
    end

endmodule

// File: rtl/dp_ram_bridge.sv
// Arbitrated bridge between the byte-wide LPC port (A) and the word-wide MCU
// port (B) onto a single synchronous buffer RAM.
//
//  state     | meaning
//  ----------+-------------------------------------------------------------
//  ST_IDLE   | sample requests, arbitrate, latch the winning access
//  ST_ACCESS | one-cycle RAM strobe (suppressed for out-of-range / empty BE)
//  ST_WAIT   | read only: count down RD_LAT cycles, capture data on the last
//  ST_ACK    | one-cycle ack to the granted port; requests ignored
module dp_ram_bridge
    import dp_ram_pkg::*;
#(
    parameter  int DATA_W     = 32,
    parameter  int DEPTH      = 512,
    parameter  int RD_LAT     = 1,
    parameter  int BIG_ENDIAN = 0,
    parameter  int ARB_RR     = 0,
    localparam int LANES      = DATA_W / 8,
    localparam int LB         = $clog2(LANES),
    localparam int WA_W       = $clog2(DEPTH),
    localparam int ADDR_W     = WA_W + LB
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              a_req_i,
    input  logic              a_we_i,
    input  logic [15:0]       a_addr_i,
    input  logic [7:0]        a_wdata_i,
    output logic [7:0]        a_rdata_o,
    output logic              a_ack_o,
    output logic              a_err_o,
    input  logic              b_req_i,
    input  logic              b_we_i,
    input  logic [WA_W-1:0]   b_addr_i,
    input  logic [LANES-1:0]  b_be_i,
    input  logic [DATA_W-1:0] b_wdata_i,
    output logic [DATA_W-1:0] b_rdata_o,
    output logic              b_ack_o,
    output logic [WA_W-1:0]   ram_addr_o,
    output logic [DATA_W-1:0] ram_wdata_o,
    output logic [LANES-1:0]  ram_be_o,
    output logic              ram_we_o,
    output logic              ram_re_o,
    input  logic [DATA_W-1:0] ram_rdata_i
);

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_sel_b;
    logic              r_we;
    logic              r_oor;
    logic              r_rr_ptr;      // 1: B wins the next tie
    logic [WA_W-1:0]   r_addr;
    logic [LB-1:0]     r_lane;
    logic [7:0]        r_a_byte;
    logic [DATA_W-1:0] r_b_wdata;
    logic [LANES-1:0]  r_b_be;
    logic [1:0]        r_lat_cnt;
    logic [7:0]        r_a_rdata;
    logic [DATA_W-1:0] r_b_rdata;

    logic              w_grant_b;
    logic              w_a_oor;
    logic              w_start;
    logic              w_rd_done;
    logic [LANES-1:0]  w_a_be;
    logic [DATA_W-1:0] w_a_wdata;
    logic [7:0]        w_a_rbyte;

    assign w_a_oor   = a_addr_i[15:ADDR_W] != '0;
    assign w_grant_b = b_req_i && (!a_req_i || ((ARB_RR != 0) && r_rr_ptr));
    assign w_start   = (r_state == ST_IDLE) && (a_req_i || b_req_i);
    assign w_rd_done = (r_state == ST_WAIT) && (r_lat_cnt == '0);

    assign a_rdata_o = r_a_rdata;
    assign b_rdata_o = r_b_rdata;

    dp_lane_mux #(
        .DATA_W     (DATA_W),
        .BIG_ENDIAN (BIG_ENDIAN)
    ) u_lane_mux (
        .i_lane  (r_lane),
        .i_wbyte (r_a_byte),
        .i_word  (ram_rdata_i),
        .o_be    (w_a_be),
        .o_wdata (w_a_wdata),
        .o_rbyte (w_a_rbyte)
    );

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Latch the granted access in IDLE; the RR pointer moves only on a grant.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_sel_b   <= 1'b0;
            r_we      <= 1'b0;
            r_oor     <= 1'b0;
            r_rr_ptr  <= 1'b0;
            r_addr    <= '0;
            r_lane    <= '0;
            r_a_byte  <= '0;
            r_b_wdata <= '0;
            r_b_be    <= '0;
        end else if (w_start) begin
            r_sel_b  <= w_grant_b;
            r_rr_ptr <= !w_grant_b;
            if (w_grant_b) begin
                r_we      <= b_we_i;
                r_addr    <= b_addr_i;
                r_b_wdata <= b_wdata_i;
                r_b_be    <= b_be_i;
                r_oor     <= 1'b0;
            end else begin
                r_we     <= a_we_i;
                r_addr   <= a_addr_i[ADDR_W-1:LB];
                r_lane   <= a_addr_i[LB-1:0];
                r_a_byte <= a_wdata_i;
                r_oor    <= w_a_oor;
            end
        end
    end

    // Read-latency down-counter; WAIT ends on terminal count zero.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_lat_cnt <= '0;
        end else if (r_state == ST_ACCESS) begin
            r_lat_cnt <= 2'(RD_LAT - 1);
        end else if ((r_state == ST_WAIT) && (r_lat_cnt != '0)) begin
            r_lat_cnt <= r_lat_cnt - 2'd1;
        end
    end

    // Capture read data for the granted port; out-of-range byte reads give 0xFF.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_a_rdata <= '0;
            r_b_rdata <= '0;
        end else if (w_rd_done) begin
            if (r_sel_b) r_b_rdata <= ram_rdata_i;
            else         r_a_rdata <= r_oor ? 8'hFF : w_a_rbyte;
        end
    end

    // Next state and the RAM / ack outputs decoded from the current state.
    always_comb begin
        w_state_nxt = r_state;
        ram_addr_o  = '0;
        ram_wdata_o = '0;
        ram_be_o    = '0;
        ram_we_o    = 1'b0;
        ram_re_o    = 1'b0;
        a_ack_o     = 1'b0;
        a_err_o     = 1'b0;
        b_ack_o     = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (a_req_i || b_req_i) w_state_nxt = ST_ACCESS;
            end
            ST_ACCESS: begin
                ram_addr_o  = r_addr;
                ram_wdata_o = r_sel_b ? r_b_wdata : w_a_wdata;
                if (r_we && !r_oor) ram_be_o = r_sel_b ? r_b_be : w_a_be;
                ram_we_o    = r_we && !r_oor && (!r_sel_b || (r_b_be != '0));
                ram_re_o    = !r_we && !r_oor;
                w_state_nxt = r_we ? ST_ACK : ST_WAIT;
            end
            ST_WAIT: begin
                if (r_lat_cnt == '0) w_state_nxt = ST_ACK;
            end
            ST_ACK: begin
                a_ack_o     = !r_sel_b;
                a_err_o     = !r_sel_b && r_oor;
                b_ack_o     = r_sel_b;
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_dp_ram_bridge.sv
// Bench for dp_ram_bridge: two instances (LE / RD_LAT=2 / fixed priority and
// BE / RD_LAT=1 / round-robin), each on its own behavioural RAM.
module tb_dp_ram_bridge;

    logic        clk;
    logic        rst;
    logic        a_req   [2];
    logic        a_we    [2];
    logic [15:0] a_addr  [2];
    logic [7:0]  a_wdata [2];
    logic [7:0]  a_rdata [2];
    logic        a_ack   [2];
    logic        a_err   [2];
    logic        b_req   [2];
    logic        b_we    [2];
    logic [8:0]  b_addr  [2];
    logic [3:0]  b_be    [2];
    logic [31:0] b_wdata [2];
    logic [31:0] b_rdata [2];
    logic        b_ack   [2];
    logic [8:0]  ram_addr  [2];
    logic [31:0] ram_wdata [2];
    logic [3:0]  ram_be    [2];
    logic        ram_we    [2];
    logic        ram_re    [2];
    logic [31:0] ram_rdata [2];

    int n_cmp = 0;
    int n_bad = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    dp_ram_bridge #(.DATA_W(32), .DEPTH(512), .RD_LAT(2), .BIG_ENDIAN(0), .ARB_RR(0)) u_dut0 (
        .clk_i(clk), .rst_i(rst),
        .a_req_i(a_req[0]), .a_we_i(a_we[0]), .a_addr_i(a_addr[0]), .a_wdata_i(a_wdata[0]),
        .a_rdata_o(a_rdata[0]), .a_ack_o(a_ack[0]), .a_err_o(a_err[0]),
        .b_req_i(b_req[0]), .b_we_i(b_we[0]), .b_addr_i(b_addr[0]), .b_be_i(b_be[0]),
        .b_wdata_i(b_wdata[0]), .b_rdata_o(b_rdata[0]), .b_ack_o(b_ack[0]),
        .ram_addr_o(ram_addr[0]), .ram_wdata_o(ram_wdata[0]), .ram_be_o(ram_be[0]),
        .ram_we_o(ram_we[0]), .ram_re_o(ram_re[0]), .ram_rdata_i(ram_rdata[0]));

    dp_ram_bridge #(.DATA_W(32), .DEPTH(512), .RD_LAT(1), .BIG_ENDIAN(1), .ARB_RR(1)) u_dut1 (
        .clk_i(clk), .rst_i(rst),
        .a_req_i(a_req[1]), .a_we_i(a_we[1]), .a_addr_i(a_addr[1]), .a_wdata_i(a_wdata[1]),
        .a_rdata_o(a_rdata[1]), .a_ack_o(a_ack[1]), .a_err_o(a_err[1]),
        .b_req_i(b_req[1]), .b_we_i(b_we[1]), .b_addr_i(b_addr[1]), .b_be_i(b_be[1]),
        .b_wdata_i(b_wdata[1]), .b_rdata_o(b_rdata[1]), .b_ack_o(b_ack[1]),
        .ram_addr_o(ram_addr[1]), .ram_wdata_o(ram_wdata[1]), .ram_be_o(ram_be[1]),
        .ram_we_o(ram_we[1]), .ram_re_o(ram_re[1]), .ram_rdata_i(ram_rdata[1]));

    // ---------------- behavioural RAM per instance ----------------
    logic [31:0] ram_mem [2][512];
    logic [31:0] pipe    [2][2];
    logic        vld     [2][2];
    int          we_cnt  [2];
    int          re_cnt  [2];
    logic [8:0]  last_addr  [2];
    logic [3:0]  last_be    [2];
    logic [31:0] last_wdata [2];

    always @(posedge clk) begin
        logic [31:0] m;
        for (int d = 0; d < 2; d++) begin
            if (ram_we[d]) begin
                we_cnt[d]     = we_cnt[d] + 1;
                last_addr[d]  = ram_addr[d];
                last_be[d]    = ram_be[d];
                last_wdata[d] = ram_wdata[d];
                for (int p = 0; p < 4; p++) begin
                    if (ram_be[d][p]) begin
                        m = 32'hFF << (8 * p);
                        ram_mem[d][ram_addr[d]] = (ram_mem[d][ram_addr[d]] & ~m) | (ram_wdata[d] & m);
                    end
                end
            end
            if (ram_re[d]) begin
                re_cnt[d]    = re_cnt[d] + 1;
                last_addr[d] = ram_addr[d];
            end
            pipe[d][0] <= ram_mem[d][ram_addr[d]];
            vld[d][0]  <= ram_re[d];
            pipe[d][1] <= pipe[d][0];
            vld[d][1]  <= vld[d][0];
        end
    end

    // Data only valid exactly RD_LAT cycles after the strobe; poison otherwise.
    assign ram_rdata[0] = vld[0][1] ? pipe[0][1] : 32'hDEADBEEF;
    assign ram_rdata[1] = vld[1][0] ? pipe[1][0] : 32'hDEADBEEF;

    // ---------------- reference model ----------------
    // Byte store indexed by [instance][word][physical lane].
    logic [7:0]  ref_mem [2][512][4];
    logic [31:0] last_a_rd [2];
    logic [31:0] last_b_rd [2];

    task automatic model(input int d, input bit pb, input bit we, input logic [15:0] addr,
                         input logic [31:0] wdata, input logic [3:0] be,
                         output logic [31:0] er, output bit eerr, output int elat,
                         output int ewe, output int ere);
        int rl;
        int w;
        int k;
        int p;
        rl   = (d == 0) ? 2 : 1;
        er   = 0;
        eerr = 0;
        ewe  = 0;
        ere  = 0;
        elat = we ? 2 : 2 + rl;
        if (!pb) begin
            if (addr > 16'h07FF) begin
                eerr = 1;
                if (!we) er = 32'hFF;
            end else begin
                w = int'(addr) / 4;
                k = int'(addr) % 4;
                p = (d == 1) ? 3 - k : k;
                if (we) begin
                    ref_mem[d][w][p] = wdata[7:0];
                    ewe = 1;
                end else begin
                    er  = {24'h0, ref_mem[d][w][p]};
                    ere = 1;
                end
            end
        end else begin
            w = int'(addr[8:0]);
            if (we) begin
                for (int q = 0; q < 4; q++)
                    if (be[q]) ref_mem[d][w][q] = 8'(wdata >> (8 * q));
                ewe = (be != 0) ? 1 : 0;
            end else begin
                er  = {ref_mem[d][w][3], ref_mem[d][w][2], ref_mem[d][w][1], ref_mem[d][w][0]};
                ere = 1;
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One transaction on one port; latency counted in clock edges from the
    // edge that samples the request (ack seen after edge number lat).
    task automatic xact(input int d, input bit pb, input bit we, input logic [15:0] addr,
                        input logic [31:0] wdata, input logic [3:0] be,
                        output logic [31:0] rdata, output bit err, output int lat);
        @(posedge clk); #1;
        if (!pb) begin
            a_req[d] = 1'b1; a_we[d] = we; a_addr[d] = addr; a_wdata[d] = wdata[7:0];
        end else begin
            b_req[d] = 1'b1; b_we[d] = we; b_addr[d] = addr[8:0]; b_be[d] = be; b_wdata[d] = wdata;
        end
        lat = -1; rdata = 0; err = 0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            if (pb ? b_ack[d] : a_ack[d]) begin
                lat   = k;
                rdata = pb ? b_rdata[d] : {24'h0, a_rdata[d]};
                err   = a_err[d];
                break;
            end
        end
        a_req[d] = 1'b0;
        b_req[d] = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        last_a_rd[0] = 0; last_a_rd[1] = 0;
        last_b_rd[0] = 0; last_b_rd[1] = 0;
    endtask

    // Both ports contend; records grant order (bit 1 = B) as acks arrive.
    task automatic arb(input int d, input int na, input int nb,
                       output logic [7:0] seq, output int n);
        int ra;
        int rb;
        ra = na; rb = nb; seq = 0; n = 0;
        @(posedge clk); #1;
        a_we[d] = 0; b_we[d] = 0; a_addr[d] = 0; b_addr[d] = 0;
        a_req[d] = (ra > 0); b_req[d] = (rb > 0);
        for (int k = 0; k < 80 && (ra > 0 || rb > 0); k++) begin
            @(posedge clk); #1;
            if (a_ack[d]) begin seq = {seq[6:0], 1'b0}; n++; ra--; a_req[d] = (ra > 0); end
            if (b_ack[d]) begin seq = {seq[6:0], 1'b1}; n++; rb--; b_req[d] = (rb > 0); end
        end
        a_req[d] = 1'b0;
        b_req[d] = 1'b0;
    endtask

    function automatic int dut_ones(input int d);
        return $countones({a_rdata[d], a_ack[d], a_err[d], b_rdata[d], b_ack[d], ram_addr[d],
                           ram_wdata[d], ram_be[d], ram_we[d], ram_re[d]});
    endfunction

    typedef struct {
        int          d;
        bit          pb;
        bit          we;
        logic [15:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] rdata;
        bit          err;
        int          lat;
        bit          strobe;
        logic [8:0]  raddr;
        logic [3:0]  rbe;
    } vec_t;

    vec_t vec [12];

    initial begin
        logic [31:0] rd;
        logic [31:0] er;
        logic [7:0]  seq;
        bit          err;
        bit          eerr;
        int          lat;
        int          elat;
        int          ewe;
        int          ere;
        int          w0;
        int          r0;
        int          n;
        int          seen;
        int          d;
        bit          pb;
        bit          we;
        logic [15:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;

        //         d pb we addr      wdata          be       rdata          err lat stb raddr rbe
        vec[0]  = '{0, 0, 1, 16'h0006, 32'h5A,       4'b0000, 32'h0,         0, 2, 1, 9'd1, 4'b0100};
        vec[1]  = '{0, 0, 0, 16'h0006, 32'h0,        4'b0000, 32'h5A,        0, 4, 1, 9'd1, 4'b0000};
        vec[2]  = '{1, 0, 1, 16'h0004, 32'h11,       4'b0000, 32'h0,         0, 2, 1, 9'd1, 4'b1000};
        vec[3]  = '{1, 1, 0, 16'h0001, 32'h0,        4'b0000, 32'h11000000,  0, 3, 1, 9'd1, 4'b0000};
        vec[4]  = '{0, 0, 0, 16'h0800, 32'h0,        4'b0000, 32'hFF,        1, 4, 0, 9'd0, 4'b0000};
        vec[5]  = '{0, 0, 1, 16'h0800, 32'hAA,       4'b0000, 32'h0,         1, 2, 0, 9'd0, 4'b0000};
        vec[6]  = '{0, 1, 1, 16'h0001, 32'h12345678, 4'b0000, 32'h0,         0, 2, 0, 9'd0, 4'b0000};
        vec[7]  = '{0, 1, 1, 16'h0001, 32'hAABBCCDD, 4'b1010, 32'h0,         0, 2, 1, 9'd1, 4'b1010};
        vec[8]  = '{0, 1, 0, 16'h0001, 32'h0,        4'b0000, 32'hAA5ACC00,  0, 4, 1, 9'd1, 4'b0000};
        vec[9]  = '{0, 0, 0, 16'h0007, 32'h0,        4'b0000, 32'hAA,        0, 4, 1, 9'd1, 4'b0000};
        vec[10] = '{1, 0, 0, 16'h0004, 32'h0,        4'b0000, 32'h11,        0, 3, 1, 9'd1, 4'b0000};
        vec[11] = '{1, 0, 0, 16'hFFFF, 32'h0,        4'b0000, 32'hFF,        1, 3, 0, 9'd0, 4'b0000};

        for (int i = 0; i < 2; i++) begin
            a_req[i] = 0; a_we[i] = 0; a_addr[i] = 0; a_wdata[i] = 0;
            b_req[i] = 0; b_we[i] = 0; b_addr[i] = 0; b_be[i] = 0; b_wdata[i] = 0;
            we_cnt[i] = 0; re_cnt[i] = 0;
            vld[i][0] = 0; vld[i][1] = 0;
            for (int w = 0; w < 512; w++) begin
                ram_mem[i][w] = 0;
                for (int p = 0; p < 4; p++) ref_mem[i][w][p] = 0;
            end
        end

        do_reset();
        chk("reset_outputs_dut0", dut_ones(0), 0);
        chk("reset_outputs_dut1", dut_ones(1), 0);

        // Directed vectors.
        for (int i = 0; i < 12; i++) begin
            model(vec[i].d, vec[i].pb, vec[i].we, vec[i].addr, vec[i].wdata, vec[i].be,
                  er, eerr, elat, ewe, ere);
            w0 = we_cnt[vec[i].d];
            r0 = re_cnt[vec[i].d];
            xact(vec[i].d, vec[i].pb, vec[i].we, vec[i].addr, vec[i].wdata, vec[i].be, rd, err, lat);
            chk($sformatf("vec%0d_latency", i), lat, vec[i].lat);
            chk($sformatf("vec%0d_err", i), 32'(err), 32'(vec[i].err));
            if (!vec[i].we) chk($sformatf("vec%0d_rdata", i), rd, vec[i].rdata);
            chk($sformatf("vec%0d_we_strobes", i), we_cnt[vec[i].d] - w0, (vec[i].we && vec[i].strobe) ? 1 : 0);
            chk($sformatf("vec%0d_re_strobes", i), re_cnt[vec[i].d] - r0, (!vec[i].we && vec[i].strobe) ? 1 : 0);
            if (vec[i].strobe) chk($sformatf("vec%0d_ram_addr", i), 32'(last_addr[vec[i].d]), 32'(vec[i].raddr));
            if (vec[i].we && vec[i].strobe) begin
                chk($sformatf("vec%0d_ram_be", i), 32'(last_be[vec[i].d]), 32'(vec[i].rbe));
                chk($sformatf("vec%0d_ram_wdata", i), last_wdata[vec[i].d],
                    vec[i].pb ? vec[i].wdata : {4{vec[i].wdata[7:0]}});
            end
        end

        // Reset during WAIT of a dut0 read aborts it.
        @(posedge clk); #1;
        a_req[0] = 1; a_we[0] = 0; a_addr[0] = 16'h0006;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1; a_req[0] = 0;
        @(posedge clk); #1;
        rst = 0;
        last_a_rd[0] = 0; last_a_rd[1] = 0; last_b_rd[0] = 0; last_b_rd[1] = 0;
        chk("rst_wait_outputs", dut_ones(0), 0);
        seen = 0;
        r0 = re_cnt[0];
        repeat (5) begin
            @(posedge clk); #1;
            if (a_ack[0] || b_ack[0]) seen++;
        end
        chk("rst_wait_no_ack", seen, 0);
        chk("rst_wait_no_strobe", re_cnt[0] - r0, 0);
        model(0, 0, 0, 16'h0006, 0, 0, er, eerr, elat, ewe, ere);
        xact(0, 0, 0, 16'h0006, 0, 0, rd, err, lat);
        chk("after_rst_rdata", rd, er);
        chk("after_rst_latency", lat, elat);
        last_a_rd[0] = er;

        // Randomized traffic against the byte-array model.
        for (int i = 0; i < 200; i++) begin
            d  = $urandom_range(0, 1);
            pb = 1'($urandom_range(0, 1));
            we = 1'($urandom_range(0, 1));
            if (!pb) addr = ($urandom_range(0, 7) == 0) ? 16'($urandom_range(2048, 65535))
                                                        : 16'($urandom_range(0, 63));
            else     addr = 16'($urandom_range(0, 15));
            wdata = $urandom;
            be    = 4'($urandom_range(0, 15));
            model(d, pb, we, addr, wdata, be, er, eerr, elat, ewe, ere);
            w0 = we_cnt[d];
            r0 = re_cnt[d];
            xact(d, pb, we, addr, wdata, be, rd, err, lat);
            chk($sformatf("rnd%0d_latency", i), lat, elat);
            chk($sformatf("rnd%0d_err", i), 32'(err), 32'(eerr));
            if (!we) begin
                chk($sformatf("rnd%0d_rdata", i), rd, er);
                if (pb) last_b_rd[d] = er;
                else    last_a_rd[d] = er;
            end
            chk($sformatf("rnd%0d_we_strobes", i), we_cnt[d] - w0, ewe);
            chk($sformatf("rnd%0d_re_strobes", i), re_cnt[d] - r0, ere);
            chk($sformatf("rnd%0d_a_rdata_hold", i), {24'h0, a_rdata[d]}, last_a_rd[d]);
            chk($sformatf("rnd%0d_b_rdata_hold", i), b_rdata[d], last_b_rd[d]);
        end

        // Arbitration: fixed priority starves B while A keeps requesting;
        // round-robin alternates starting with A after reset.
        do_reset();
        arb(0, 2, 1, seq, n);
        chk("arb_fixed_count", n, 3);
        chk("arb_fixed_order", 32'(seq), 32'b001);
        arb(1, 2, 2, seq, n);
        chk("arb_rr_count", n, 4);
        chk("arb_rr_order", 32'(seq), 32'b0101);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
